bram_dp_responder: RTL and testbench
====================================

Name: bram_dp_responder

Overview:
- Synthesizable true-dual-port 512x16 block-RAM responder.
- Services the en/we/addr/din/dout request protocol that our read-modify-write walker issues on ports A and B.
- Adds a post-reset fill sweep, a configurable read latency, cross-port collision resolution and counting, and per-port read-valid strobes.
- Used as the memory endpoint in simulation and on-board bring-up.

Parameters:
- DEPTH, 512, number of 16-bit words; the address is 9 bits.
- READ_LAT, 2, cycles from an accepted read to valid dout; legal values are 1 or 2.
- INIT_VALUE, 16'h0000, base fill value written during the reset sweep.
- INIT_INCR, 1'b0, when 1, word k is filled with INIT_VALUE+k (mod 2^16).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en_a  in  1  port A enable
- we_a  in  1  port A write enable; qualified by en_a
- addr_a  in  9  port A address
- din_a  in  16  port A write data
- dout_a  out  16  port A read data
- rd_valid_a  out  1  one-cycle pulse when dout_a carries new read data
- en_b, we_b, addr_b, din_b, dout_b, rd_valid_b: same as port A, for port B
- ready  out  1  high when the fill sweep is done and requests are accepted
- collision  out  1  one-cycle pulse, registered, on a cross-port address collision
- collision_count  out  8  saturating count of collisions since reset

Behaviour:
- Reset values: dout_a=dout_b=0, rd_valid_a=rd_valid_b=0, ready=0, collision=0, collision_count=0, read pipelines flushed.
- The memory array itself is not cleared by reset; the fill sweep overwrites it.
- FSM states:
  - S_FILL: entered on reset. An internal counter walks addresses 0..DEPTH-1, writing one word per cycle.
  - S_READY: entered on the cycle after address DEPTH-1 is written. ready rises on entry, 512 cycles after rst deasserts.
  - rst in either state returns to S_FILL with the counter at 0. A sweep interrupted by reset restarts from address 0.
- During S_FILL:
  - All port requests are ignored: no writes, no rd_valid.
  - dout_a and dout_b hold 0.
- Accepted request: en_x=1 while ready=1.
  - we_x=1 means write; we_x=0 means read.
  - en_x=0 means no access; dout_x holds its last value.
- Read latency:
  - READ_LAT=1: array data is registered into dout_x at the edge that accepts the read.
  - READ_LAT=2: one extra output register stage.
  - rd_valid_x pulses in the same cycle dout_x first shows the new data, and is pipelined with it.
  - Back-to-back reads give one result per cycle.
- Same-port write: read-first. dout_x is unchanged and no rd_valid_x pulse is produced; the write takes effect for any read accepted on a later cycle.
- Cross-port collision (both ports accepted, addr_a==addr_b, at least one write):
  - Both write: port A data is stored and port B's write is dropped.
  - One writes, the other reads: the reader gets the old (pre-write) data, and the write is stored.
  - Both read, same address: not a collision; both ports return the data.
  - Any collision: collision pulses the next cycle; collision_count increments and saturates at 255.
- Address wrap: addresses are 9-bit, so there is no out-of-range access. Address 511 is valid; the next address after it is the caller's concern.
- Fill arithmetic: INIT_VALUE+k is computed in 16 bits and wraps modulo 2^16.
- Reset during READY: in-flight reads are discarded. No rd_valid pulse is produced after reset, even one due in that cycle.

Test Plan:
1. Fill sweep: rst high for 2 cycles, then low, INIT_INCR=1, INIT_VALUE=16'h1000 -> ready=0 for exactly 512 cycles, then 1. Port A reads of addr 0, 1, 511 return 16'h1000, 16'h1001, 16'h11FF.
2. Read latency: READ_LAT=2, read A addr 2 at cycle t -> rd_valid_a and the data appear at t+2. Repeat with READ_LAT=1 -> they appear at t+1. Reads at consecutive cycles on addr 0..3 -> four consecutive rd_valid pulses with the correct data.
3. Walker RMW: read addr 508 (value v), write v+1 on A, then read on B three cycles later -> dout_b=v+1, rd_valid_b pulses once. Repeat for addresses 0, 1, 2, 508, 509, 510, 511 with no collision pulses.
4. Collision:
   - A writes 16'hAAAA and B writes 16'hBBBB to addr 5 in the same cycle -> a later read of addr 5 returns 16'hAAAA; collision pulses once and collision_count=1.
   - A writes 16'h1234 while B reads addr 5 (old value 16'hAAAA) -> dout_b=16'hAAAA, collision_count=2.
5. Saturation: 300 back-to-back colliding writes -> collision_count stops at 255; the collision pulse continues each cycle.
6. Reset mid-operation:
   - rst asserted at fill address 200 -> the sweep restarts and ready rises 512 cycles after release.
   - rst asserted one cycle after a READ_LAT=2 read -> no rd_valid pulse; dout=0.

Source files
------------

// File: rtl/bram_dp_responder.sv
// True-dual-port 512x16 block-RAM responder. Runs a fill sweep after reset, then serves the
// en/we/addr/din request protocol on two ports with 1- or 2-cycle read latency.
module bram_dp_responder #(
  parameter int          DEPTH      = 512,
  parameter int          READ_LAT   = 2,
  parameter logic [15:0] INIT_VALUE = 16'h0000,
  parameter logic        INIT_INCR  = 1'b0,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [15:0]   din_a,
  output logic [15:0]   dout_a,
  output logic          rd_valid_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [15:0]   din_b,
  output logic [15:0]   dout_b,
  output logic          rd_valid_b,
  output logic          ready,
  output logic          collision,
  output logic [7:0]    collision_count
);

  typedef enum logic {S_FILL, S_READY} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] fill_cnt_reg, fill_cnt_next;
  logic          fill_we;
  logic [15:0]   fill_data;

  logic [1:0]    en_v, we_v, acc_v, rd_v, rdv_v;
  logic [AW-1:0] addr_v [2];
  logic [15:0]   dout_v [2];
  logic          same_addr, wr_a, wr_b, col_now;
  logic          wa_en;
  logic [AW-1:0] wa_addr;
  logic [15:0]   wa_data;
  logic          collision_reg;
  logic [7:0]    collision_count_reg;

  logic [15:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FILL;
      fill_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    case (state_reg)
      S_FILL: begin
        fill_cnt_next = fill_cnt_reg + AW'(1);
        if (fill_cnt_reg == AW'(DEPTH - 1))
          state_next = S_READY;
      end
      default: state_next = S_READY;
    endcase
  end

  always_comb begin
    ready   = (state_reg == S_READY);
    fill_we = (state_reg == S_FILL) && !rst;
  end

  assign fill_data = INIT_INCR ? (INIT_VALUE + 16'(fill_cnt_reg)) : INIT_VALUE;

  assign en_v      = {en_b, en_a};
  assign we_v      = {we_b, we_a};
  assign addr_v[0] = addr_a;
  assign addr_v[1] = addr_b;
  assign acc_v     = en_v & {2{ready && !rst}};
  assign rd_v      = acc_v & ~we_v;
  assign same_addr = (addr_a == addr_b);
  assign col_now   = (&acc_v) && same_addr && (|we_v);

  // Port A wins a same-address double write; the fill sweep borrows port A's write path.
  assign wr_a    = acc_v[0] && we_a;
  assign wr_b    = acc_v[1] && we_b && !(wr_a && same_addr);
  assign wa_en   = fill_we || wr_a;
  assign wa_addr = fill_we ? fill_cnt_reg : addr_a;
  assign wa_data = fill_we ? fill_data : din_a;

  always_ff @(posedge clk) begin
    if (wa_en)
      mem[wa_addr] <= wa_data;
    if (wr_b)
      mem[addr_b] <= din_b;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [15:0] q_reg;
      logic        v1_reg;

      // Read-first: the registered read sees the word as it was before this edge's writes.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg  <= '0;
          v1_reg <= 1'b0;
        end else begin
          v1_reg <= rd_v[gi];
          if (rd_v[gi])
            q_reg <= mem[addr_v[gi]];
        end
      end

      if (READ_LAT == 1) begin : g_lat1
        assign dout_v[gi] = q_reg;
        assign rdv_v[gi]  = v1_reg;
      end else begin : g_lat2
        logic [15:0] d2_reg;
        logic        v2_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            d2_reg <= '0;
            v2_reg <= 1'b0;
          end else begin
            v2_reg <= v1_reg;
            if (v1_reg)
              d2_reg <= q_reg;
          end
        end
        assign dout_v[gi] = d2_reg;
        assign rdv_v[gi]  = v2_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_reg       <= 1'b0;
      collision_count_reg <= '0;
    end else begin
      collision_reg <= col_now;
      if (col_now && collision_count_reg != 8'hFF)
        collision_count_reg <= collision_count_reg + 8'd1;
    end
  end

  assign dout_a          = dout_v[0];
  assign dout_b          = dout_v[1];
  assign rd_valid_a      = rdv_v[0];
  assign rd_valid_b      = rdv_v[1];
  assign collision       = collision_reg;
  assign collision_count = collision_count_reg;

endmodule

// File: tb/tb_bram_dp_responder.sv
// Drives two responders (READ_LAT 1 and 2) with identical requests and checks every cycle
// against a word-array model with a per-port schedule of pending read results.
module tb_bram_dp_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, we_a, en_b, we_b;
  logic [8:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  logic [1:0][15:0] dout_a_o, dout_b_o;
  logic [1:0]       rdv_a_o, rdv_b_o, ready_o, col_o;
  logic [1:0][7:0]  cnt_o;

  bram_dp_responder #(.DEPTH(512), .READ_LAT(1), .INIT_VALUE(16'h1000), .INIT_INCR(1'b1)) u_lat1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a_o[0]), .rd_valid_a(rdv_a_o[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b_o[0]), .rd_valid_b(rdv_b_o[0]),
    .ready(ready_o[0]), .collision(col_o[0]), .collision_count(cnt_o[0])
  );

  bram_dp_responder #(.DEPTH(512), .READ_LAT(2), .INIT_VALUE(16'h1000), .INIT_INCR(1'b1)) u_lat2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a_o[1]), .rd_valid_a(rdv_a_o[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b_o[1]), .rd_valid_b(rdv_b_o[1]),
    .ready(ready_o[1]), .collision(col_o[1]), .collision_count(cnt_o[1])
  );

  // Reference model
  logic [15:0] m_mem [512];
  int          m_fill;
  bit          m_ready;
  bit          m_col;
  int          m_cnt;
  int          cyc;
  logic [15:0] exp_dout [2][2];
  bit          sch_v [2][2][4];
  logic [15:0] sch_d [2][2][4];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    bit          acc_a, acc_b;
    logic [15:0] old_a, old_b;
    bit          ev [2][2];
    int          due, s;
    acc_a = en_a && m_ready && !rst;
    acc_b = en_b && m_ready && !rst;
    old_a = m_mem[addr_a];
    old_b = m_mem[addr_b];
    @(posedge clk);
    #1;
    cyc++;
    for (int li = 0; li < 2; li++)
      for (int p = 0; p < 2; p++)
        ev[li][p] = 1'b0;
    if (rst) begin
      m_fill  = 0;
      m_ready = 1'b0;
      m_col   = 1'b0;
      m_cnt   = 0;
      for (int li = 0; li < 2; li++)
        for (int p = 0; p < 2; p++) begin
          exp_dout[li][p] = 16'h0000;
          for (int k = 0; k < 4; k++) sch_v[li][p][k] = 1'b0;
        end
    end else begin
      if (!m_ready) begin
        m_mem[m_fill] = 16'h1000 + 16'(m_fill);
        m_fill++;
        if (m_fill == 512) m_ready = 1'b1;
      end
      m_col = acc_a && acc_b && (addr_a == addr_b) && (we_a || we_b);
      if (m_col && m_cnt < 255) m_cnt++;
      if (acc_a && we_a) m_mem[addr_a] = din_a;
      if (acc_b && we_b && !(acc_a && we_a && addr_a == addr_b)) m_mem[addr_b] = din_b;
      for (int li = 0; li < 2; li++) begin
        due = (cyc + li) % 4;
        if (acc_a && !we_a) begin sch_v[li][0][due] = 1'b1; sch_d[li][0][due] = old_a; end
        if (acc_b && !we_b) begin sch_v[li][1][due] = 1'b1; sch_d[li][1][due] = old_b; end
        s = cyc % 4;
        for (int p = 0; p < 2; p++)
          if (sch_v[li][p][s]) begin
            ev[li][p]       = 1'b1;
            exp_dout[li][p] = sch_d[li][p][s];
            sch_v[li][p][s] = 1'b0;
          end
      end
    end
    if (acc_a || acc_b)
      $display("[TB] c%0d A en%0d we%0d @%0d d=%h | B en%0d we%0d @%0d d=%h", cyc,
               acc_a, we_a, addr_a, din_a, acc_b, we_b, addr_b, din_b);
    for (int li = 0; li < 2; li++) begin
      chk($sformatf("L%0d ready c%0d", li + 1, cyc), 32'(ready_o[li]), 32'(m_ready));
      chk($sformatf("L%0d collision c%0d", li + 1, cyc), 32'(col_o[li]), 32'(m_col));
      chk($sformatf("L%0d count c%0d", li + 1, cyc), 32'(cnt_o[li]), 32'(m_cnt));
      chk($sformatf("L%0d rdv_a c%0d", li + 1, cyc), 32'(rdv_a_o[li]), 32'(ev[li][0]));
      chk($sformatf("L%0d rdv_b c%0d", li + 1, cyc), 32'(rdv_b_o[li]), 32'(ev[li][1]));
      chk($sformatf("L%0d dout_a c%0d", li + 1, cyc), 32'(dout_a_o[li]), 32'(exp_dout[li][0]));
      chk($sformatf("L%0d dout_b c%0d", li + 1, cyc), 32'(dout_b_o[li]), 32'(exp_dout[li][1]));
    end
  endtask

  task automatic req(input bit ea, input bit wa, input int aa, input logic [15:0] da,
                     input bit eb, input bit wb, input int ab, input logic [15:0] db);
    en_a = ea; we_a = wa; addr_a = 9'(aa); din_a = da;
    en_b = eb; we_b = wb; addr_b = 9'(ab); din_b = db;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
  endtask

  task automatic rand_req(input int maxaddr);
    req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, maxaddr)), 16'($urandom),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, maxaddr)), 16'($urandom));
  endtask

  initial begin
    logic [15:0] v;
    int          a;
    int          rmw_addrs [7];
    rmw_addrs = '{0, 1, 2, 508, 509, 510, 511};
    cyc = 0; m_fill = 0; m_ready = 1'b0; m_col = 1'b0; m_cnt = 0;
    rst = 1'b1; en_a = 0; we_a = 0; addr_a = 0; din_a = 0; en_b = 0; we_b = 0; addr_b = 0; din_b = 0;

    // Fill sweep with requests thrown at it that must all be ignored
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 512; i++) rand_req(511);
    req(1, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    chk("fill_addr0", 32'(dout_a_o[0]), 32'h1000);
    req(1, 0, 1, 16'h0, 0, 0, 0, 16'h0);
    chk("fill_addr1", 32'(dout_a_o[0]), 32'h1001);
    req(1, 0, 511, 16'h0, 0, 0, 0, 16'h0);
    chk("fill_addr511", 32'(dout_a_o[0]), 32'h11FF);
    idle(3);

    // Single read and back-to-back reads
    req(1, 0, 2, 16'h0, 0, 0, 0, 16'h0);
    idle(3);
    for (int i = 0; i < 4; i++) req(1, 0, i, 16'h0, 1, 0, 3 - i, 16'h0);
    idle(3);

    // Walker read-modify-write at the address extremes
    for (int i = 0; i < 7; i++) begin
      a = rmw_addrs[i];
      req(1, 0, a, 16'h0, 0, 0, 0, 16'h0);
      idle(1);
      v = m_mem[a] + 16'd1;
      req(1, 1, a, v, 0, 0, 0, 16'h0);
      idle(2);
      req(0, 0, 0, 16'h0, 1, 0, a, 16'h0);
      idle(2);
      chk($sformatf("rmw_b_%0d", a), 32'(dout_b_o[1]), 32'(v));
    end

    // Cross-port collisions
    req(1, 1, 5, 16'hAAAA, 1, 1, 5, 16'hBBBB);
    idle(1);
    req(1, 0, 5, 16'h0, 0, 0, 0, 16'h0);
    idle(2);
    chk("coll_ww_data", 32'(dout_a_o[1]), 32'hAAAA);
    chk("coll_ww_count", 32'(cnt_o[1]), 32'd1);
    req(1, 1, 5, 16'h1234, 1, 0, 5, 16'h0);
    idle(2);
    chk("coll_wr_old", 32'(dout_b_o[1]), 32'hAAAA);
    chk("coll_wr_count", 32'(cnt_o[0]), 32'd2);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 511));
      req(1, 1, a, 16'($urandom), 1, 1, a, 16'($urandom));
    end
    idle(1);
    chk("sat_count", 32'(cnt_o[1]), 32'd255);

    // Mixed random traffic on a small address window to provoke collisions
    for (int i = 0; i < 400; i++) rand_req(7);
    idle(3);

    // Reset in the middle of the fill sweep
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int i = 0; i < 200; i++) rand_req(511);
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int i = 0; i < 512; i++) rand_req(511);
    for (int i = 0; i < 40; i++) rand_req(15);
    idle(3);

    // Reset one cycle after an accepted read discards it
    req(1, 0, 3, 16'h0, 1, 0, 4, 16'h0);
    rst = 1'b1;
    req(1, 0, 6, 16'h0, 1, 0, 7, 16'h0);
    rst = 1'b0;
    idle(3);
    chk("rst_flush_dout", 32'(dout_a_o[1]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
